id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, with integrated load-use hazard detection.
- Captures decoded operands and control from ID and presents them to EX: the operand muxes, the ALU and the forwarding unit, which consumes the RS1/RS2 addresses and RegWrite/RD.
- Inserts a one-cycle bubble on load-use hazards or branch flush, and holds the pipeline on global freeze.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- XLEN, 32, width of register data and immediate.
- CNT_W, 16, width of each event counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- freeze_i  in  1  global pipeline hold (e.g. memory stall); highest priority.
- Flush_i  in  1  squash the instruction currently in ID (branch taken).
- valid_ID_i  in  1  ID holds a real instruction.
- RS1addr_ID_i  in  5  source 1 address.
- RS2addr_ID_i  in  5  source 2 address.
- RDaddr_ID_i  in  5  destination address.
- RS1use_ID_i  in  1  instruction reads rs1.
- RS2use_ID_i  in  1  instruction reads rs2.
- RS1data_ID_i  in  XLEN  register file read data 1.
- RS2data_ID_i  in  XLEN  register file read data 2.
- Imm_ID_i  in  XLEN  sign-extended immediate.
- funct_ID_i  in  10  {funct7, funct3}.
- ALUOp_ID_i  in  2  ALU control class.
- ALUSrc_ID_i  in  1  ALU control bit.
- RegWrite_ID_i  in  1  control bit.
- MemtoReg_ID_i  in  1  control bit.
- MemRead_ID_i  in  1  control bit.
- MemWrite_ID_i  in  1  control bit.
- Outputs: each input above from valid_ID_i through MemWrite_ID_i, except RS1use/RS2use, has a registered counterpart named *_ID_EX_o with the same width.
- valid_ID_EX_o  out  1  EX holds a real instruction.
- Stall_o  out  1  combinational; hold PC and IF/ID this cycle.
- stall_cnt_o  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt_o  out  CNT_W  flush cycles, saturating.

Behaviour:
- Reset (rst_i=0 at rising edge): every registered output, including both counters, becomes 0. rst_i overrides freeze_i.
- Hazard, combinational:
  - haz = valid_ID_i & valid_ID_EX_o & MemRead_ID_EX_o & (RDaddr_ID_EX_o != 0) & ((RS1use_ID_i & RDaddr_ID_EX_o == RS1addr_ID_i) | (RS2use_ID_i & RDaddr_ID_EX_o == RS2addr_ID_i)).
  - Stall_o = haz & ~Flush_i. A squashed instruction never waits.
- Register update priority per edge, when not in reset:
  1. freeze_i=1: all registers, including counters, hold.
  2. Flush_i=1: bubble.
  3. Stall_o=1: bubble.
  4. Otherwise: load all *_ID_EX_o from the ID inputs. valid_ID_EX_o = valid_ID_i.
- Bubble: all registered pipeline outputs, control, addresses and data, are set to 0, so downstream forwarding sees no match.
- Load latency: 1 cycle from ID inputs to *_ID_EX_o.
- Load-use stall lasts exactly 1 cycle. The bubble clears MemRead_ID_EX_o, so haz drops on the next cycle and the held ID instruction loads.
- RD=x0 never causes a stall. A load with valid_ID_EX_o=0 never causes a stall.
- freeze_i=1 with haz=1: Stall_o stays asserted, registers hold, and the stall resolves after freeze_i drops.
- Counters:
  - stall_cnt_o increments on edges where ~freeze_i & Stall_o.
  - flush_cnt_o increments on edges where ~freeze_i & Flush_i.
  - Both saturate at 2^CNT_W-1 and never wrap.
- No combinational path exists from ID inputs to registered outputs. Stall_o is the only combinational output.

Test Plan:
1. Reset: rst_i=0 for 2 edges with random inputs and freeze_i=1 -> all outputs 0, counters 0, Stall_o=0.
2. Pass-through: valid ID instruction with RD=7, Imm=0xFFFFFFF0, RegWrite=1 -> one edge later RDaddr_ID_EX_o=7, Imm_ID_EX_o=0xFFFFFFF0, RegWrite_ID_EX_o=1, valid_ID_EX_o=1.
3. Load-use: EX holds lw x5 (MemRead=1, valid=1); ID holds add with rs1=5, RS1use=1 -> Stall_o=1. Next edge: all ID_EX outputs 0, stall_cnt_o=1. Following cycle: Stall_o=0, and the add loads on the next edge.
4. Non-hazards:
   - lw x0 with rs1=0 -> Stall_o=0.
   - lw x5 with ID rs2=5 but RS2use=0 -> Stall_o=0.
5. Flush with simultaneous hazard: setup of scenario 3 plus Flush_i=1 -> Stall_o=0, bubble loaded, flush_cnt_o=1, stall_cnt_o=0.
6. Freeze and saturation:
   - freeze_i=1 for 3 cycles during a hazard -> outputs and counters hold, Stall_o stays 1.
   - Then rst_i=0 mid-freeze -> all 0.
   - With CNT_W=4, 20 stall events -> stall_cnt_o=15.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID -> EX stage bundle: decoded ID operands/control and hold/squash controls in,
// EX-side pipeline register, stall request and event counters out.
interface id_ex_stage_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
);
   logic             freeze_i;
   logic             Flush_i;
   logic             valid_ID_i;
   logic [4:0]       RS1addr_ID_i;
   logic [4:0]       RS2addr_ID_i;
   logic [4:0]       RDaddr_ID_i;
   logic             RS1use_ID_i;
   logic             RS2use_ID_i;
   logic [XLEN-1:0]  RS1data_ID_i;
   logic [XLEN-1:0]  RS2data_ID_i;
   logic [XLEN-1:0]  Imm_ID_i;
   logic [9:0]       funct_ID_i;
   logic [1:0]       ALUOp_ID_i;
   logic             ALUSrc_ID_i;
   logic             RegWrite_ID_i;
   logic             MemtoReg_ID_i;
   logic             MemRead_ID_i;
   logic             MemWrite_ID_i;

   logic             valid_ID_EX_o;
   logic [4:0]       RS1addr_ID_EX_o;
   logic [4:0]       RS2addr_ID_EX_o;
   logic [4:0]       RDaddr_ID_EX_o;
   logic [XLEN-1:0]  RS1data_ID_EX_o;
   logic [XLEN-1:0]  RS2data_ID_EX_o;
   logic [XLEN-1:0]  Imm_ID_EX_o;
   logic [9:0]       funct_ID_EX_o;
   logic [1:0]       ALUOp_ID_EX_o;
   logic             ALUSrc_ID_EX_o;
   logic             RegWrite_ID_EX_o;
   logic             MemtoReg_ID_EX_o;
   logic             MemRead_ID_EX_o;
   logic             MemWrite_ID_EX_o;
   logic             Stall_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport master (
      output freeze_i, Flush_i, valid_ID_i, RS1addr_ID_i, RS2addr_ID_i, RDaddr_ID_i,
             RS1use_ID_i, RS2use_ID_i, RS1data_ID_i, RS2data_ID_i, Imm_ID_i, funct_ID_i,
             ALUOp_ID_i, ALUSrc_ID_i, RegWrite_ID_i, MemtoReg_ID_i, MemRead_ID_i, MemWrite_ID_i,
      input  valid_ID_EX_o, RS1addr_ID_EX_o, RS2addr_ID_EX_o, RDaddr_ID_EX_o, RS1data_ID_EX_o,
             RS2data_ID_EX_o, Imm_ID_EX_o, funct_ID_EX_o, ALUOp_ID_EX_o, ALUSrc_ID_EX_o,
             RegWrite_ID_EX_o, MemtoReg_ID_EX_o, MemRead_ID_EX_o, MemWrite_ID_EX_o,
             Stall_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  freeze_i, Flush_i, valid_ID_i, RS1addr_ID_i, RS2addr_ID_i, RDaddr_ID_i,
             RS1use_ID_i, RS2use_ID_i, RS1data_ID_i, RS2data_ID_i, Imm_ID_i, funct_ID_i,
             ALUOp_ID_i, ALUSrc_ID_i, RegWrite_ID_i, MemtoReg_ID_i, MemRead_ID_i, MemWrite_ID_i,
      output valid_ID_EX_o, RS1addr_ID_EX_o, RS2addr_ID_EX_o, RDaddr_ID_EX_o, RS1data_ID_EX_o,
             RS2data_ID_EX_o, Imm_ID_EX_o, funct_ID_EX_o, ALUOp_ID_EX_o, ALUSrc_ID_EX_o,
             RegWrite_ID_EX_o, MemtoReg_ID_EX_o, MemRead_ID_EX_o, MemWrite_ID_EX_o,
             Stall_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall/flush, global freeze, and saturating stall/flush event counters.
module id_ex_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input logic          clk_i,
   input logic          rst_i,
   id_ex_stage_if.slave bus
);
   localparam int unsigned REG_W   = 5;
   localparam int unsigned FUNCT_W = 10;
   localparam int unsigned ALUOP_W = 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic               valid;
      logic [REG_W-1:0]   rs1;
      logic [REG_W-1:0]   rs2;
      logic [REG_W-1:0]   rd;
      logic [XLEN-1:0]    rs1_data;
      logic [XLEN-1:0]    rs2_data;
      logic [XLEN-1:0]    imm;
      logic [FUNCT_W-1:0] funct;
      logic [ALUOP_W-1:0] alu_op;
      logic               alu_src;
      logic               reg_write;
      logic               mem_to_reg;
      logic               mem_read;
      logic               mem_write;
   } ex_t;

   ex_t              id_c;
   ex_t              ex_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;
   logic             rs1_hit_c;
   logic             rs2_hit_c;
   logic             haz_c;
   logic             stall_c;

   // Gather the ID-side fields into the pipeline payload.
   always_comb begin
      id_c            = '0;
      id_c.valid      = bus.valid_ID_i;
      id_c.rs1        = bus.RS1addr_ID_i;
      id_c.rs2        = bus.RS2addr_ID_i;
      id_c.rd         = bus.RDaddr_ID_i;
      id_c.rs1_data   = bus.RS1data_ID_i;
      id_c.rs2_data   = bus.RS2data_ID_i;
      id_c.imm        = bus.Imm_ID_i;
      id_c.funct      = bus.funct_ID_i;
      id_c.alu_op     = bus.ALUOp_ID_i;
      id_c.alu_src    = bus.ALUSrc_ID_i;
      id_c.reg_write  = bus.RegWrite_ID_i;
      id_c.mem_to_reg = bus.MemtoReg_ID_i;
      id_c.mem_read   = bus.MemRead_ID_i;
      id_c.mem_write  = bus.MemWrite_ID_i;
   end

   // Load-use: the load in EX writes a register the ID instruction actually reads.
   always_comb begin
      rs1_hit_c = bus.RS1use_ID_i && (ex_q.rd == bus.RS1addr_ID_i);
      rs2_hit_c = bus.RS2use_ID_i && (ex_q.rd == bus.RS2addr_ID_i);
      haz_c     = bus.valid_ID_i && ex_q.valid && ex_q.mem_read &&
                  (ex_q.rd != '0) && (rs1_hit_c || rs2_hit_c);
      // A squashed instruction never needs to wait for its operands.
      stall_c   = haz_c && !bus.Flush_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ex_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else if (!bus.freeze_i) begin
         if (bus.Flush_i || stall_c) begin
            ex_q <= '0;
         end else begin
            ex_q <= id_c;
         end
         if (stall_c && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (bus.Flush_i && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.valid_ID_EX_o    = ex_q.valid;
   assign bus.RS1addr_ID_EX_o  = ex_q.rs1;
   assign bus.RS2addr_ID_EX_o  = ex_q.rs2;
   assign bus.RDaddr_ID_EX_o   = ex_q.rd;
   assign bus.RS1data_ID_EX_o  = ex_q.rs1_data;
   assign bus.RS2data_ID_EX_o  = ex_q.rs2_data;
   assign bus.Imm_ID_EX_o      = ex_q.imm;
   assign bus.funct_ID_EX_o    = ex_q.funct;
   assign bus.ALUOp_ID_EX_o    = ex_q.alu_op;
   assign bus.ALUSrc_ID_EX_o   = ex_q.alu_src;
   assign bus.RegWrite_ID_EX_o = ex_q.reg_write;
   assign bus.MemtoReg_ID_EX_o = ex_q.mem_to_reg;
   assign bus.MemRead_ID_EX_o  = ex_q.mem_read;
   assign bus.MemWrite_ID_EX_o = ex_q.mem_write;
   assign bus.Stall_o          = stall_c;
   assign bus.stall_cnt_o      = stall_cnt_q;
   assign bus.flush_cnt_o      = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for the pipeline/hazard cases,
// hand sequences for freeze, mid-freeze reset and counter saturation.
module tb_id_ex_stage;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 4;

   typedef struct packed {
      logic            valid;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            use1;
      logic            use2;
      logic [XLEN-1:0] d1;
      logic [XLEN-1:0] d2;
      logic [XLEN-1:0] imm;
      logic [9:0]      funct;
      logic [1:0]      aluop;
      logic            alusrc;
      logic            regw;
      logic            m2r;
      logic            mrd;
      logic            mwr;
   } ins_t;

   typedef struct {
      string            name;
      logic             rst;
      logic             frz;
      logic             fl;
      ins_t             id;
      logic             chk_st;
      logic             exp_st;
      ins_t             exp_ex;
      logic [CNT_W-1:0] exp_sc;
      logic [CNT_W-1:0] exp_fc;
   } vec_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk_i = ~clk_i;

   id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

   function automatic ins_t ins(input logic v, input logic [4:0] rs1, rs2, rd,
                                input logic u1, u2, input logic [XLEN-1:0] d1, d2, imm,
                                input logic [9:0] funct, input logic [1:0] aluop,
                                input logic alusrc, regw, m2r, mrd, mwr);
      return {v, rs1, rs2, rd, u1, u2, d1, d2, imm, funct, aluop, alusrc, regw, m2r, mrd, mwr};
   endfunction

   function automatic ins_t strip(input ins_t i);
      ins_t o = i;
      o.use1 = 1'b0;
      o.use2 = 1'b0;
      return o;
   endfunction

   function automatic ins_t observe();
      return {bus.valid_ID_EX_o, bus.RS1addr_ID_EX_o, bus.RS2addr_ID_EX_o, bus.RDaddr_ID_EX_o,
              1'b0, 1'b0, bus.RS1data_ID_EX_o, bus.RS2data_ID_EX_o, bus.Imm_ID_EX_o,
              bus.funct_ID_EX_o, bus.ALUOp_ID_EX_o, bus.ALUSrc_ID_EX_o, bus.RegWrite_ID_EX_o,
              bus.MemtoReg_ID_EX_o, bus.MemRead_ID_EX_o, bus.MemWrite_ID_EX_o};
   endfunction

   function automatic vec_t mk(input string name, input logic rst, frz, fl, input ins_t id,
                               input logic chk_st, exp_st, input ins_t exp_ex,
                               input logic [CNT_W-1:0] sc, fc);
      vec_t v;
      v.name = name; v.rst = rst; v.frz = frz; v.fl = fl; v.id = id;
      v.chk_st = chk_st; v.exp_st = exp_st; v.exp_ex = exp_ex; v.exp_sc = sc; v.exp_fc = fc;
      return v;
   endfunction

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, frz, fl, input ins_t i);
      rst_i             = rst;
      bus.freeze_i      = frz;
      bus.Flush_i       = fl;
      bus.valid_ID_i    = i.valid;
      bus.RS1addr_ID_i  = i.rs1;
      bus.RS2addr_ID_i  = i.rs2;
      bus.RDaddr_ID_i   = i.rd;
      bus.RS1use_ID_i   = i.use1;
      bus.RS2use_ID_i   = i.use2;
      bus.RS1data_ID_i  = i.d1;
      bus.RS2data_ID_i  = i.d2;
      bus.Imm_ID_i      = i.imm;
      bus.funct_ID_i    = i.funct;
      bus.ALUOp_ID_i    = i.aluop;
      bus.ALUSrc_ID_i   = i.alusrc;
      bus.RegWrite_ID_i = i.regw;
      bus.MemtoReg_ID_i = i.m2r;
      bus.MemRead_ID_i  = i.mrd;
      bus.MemWrite_ID_i = i.mwr;
   endtask

   // Drive at negedge, sample Stall_o before the edge, registers #1 after it.
   task automatic step(input string name, input logic rst, frz, fl, input ins_t id,
                       input logic chk_st, exp_st, input ins_t exp_ex,
                       input logic [CNT_W-1:0] sc, fc);
      @(negedge clk_i);
      drive(rst, frz, fl, id);
      #1;
      if (chk_st) check({name, " stall"}, 160'(bus.Stall_o), 160'(exp_st));
      @(posedge clk_i);
      #1;
      check({name, " ex"}, 160'(observe()), 160'(strip(exp_ex)));
      check({name, " stall_cnt"}, 160'(bus.stall_cnt_o), 160'(sc));
      check({name, " flush_cnt"}, 160'(bus.flush_cnt_o), 160'(fc));
   endtask

   ins_t             BUB, PASS, LW5, LW5I, LW0, ADD5, ADD5I, ADD0, ADDI, SW5, RND0, RND1;
   vec_t             tbl[$];
   logic [159:0]     r;
   logic [CNT_W-1:0] s;
   logic [CNT_W-1:0] f;

   initial begin
      BUB   = '0;
      PASS  = ins(1'b1, 5'd1, 5'd3, 5'd7, 1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678, 32'hFFFFFFF0,
                  10'h100, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      LW5   = ins(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 32'h00001000, 32'h0, 32'h8,
                  10'h002, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      LW5I  = LW5;  LW5I.valid = 1'b0;
      LW0   = LW5;  LW0.rd = 5'd0;
      ADD5  = ins(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0,
                  10'h000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ADD5I = ADD5; ADD5I.valid = 1'b0;
      ADD0  = ins(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 32'h5, 32'h6, 32'h0,
                  10'h000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ADDI  = ins(1'b1, 5'd4, 5'd5, 5'd8, 1'b1, 1'b0, 32'h44, 32'h55, 32'h5,
                  10'h000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      SW5   = ins(1'b1, 5'd9, 5'd5, 5'd0, 1'b1, 1'b1, 32'h2000, 32'hCAFE, 32'h4,
                  10'h002, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      r    = {$urandom, $urandom, $urandom, $urandom, $urandom};
      RND0 = ins_t'(r[$bits(ins_t)-1:0]);
      r    = {$urandom, $urandom, $urandom, $urandom, $urandom};
      RND1 = ins_t'(r[$bits(ins_t)-1:0]);

      //                  name        rst   frz   fl    id     chk   st    exp_ex sc    fc
      tbl.push_back(mk("rst0",     1'b0, 1'b1, 1'b0, RND0,  1'b0, 1'b0, BUB,  4'd0, 4'd0));
      tbl.push_back(mk("rst1",     1'b0, 1'b1, 1'b1, RND1,  1'b1, 1'b0, BUB,  4'd0, 4'd0));
      tbl.push_back(mk("pass",     1'b1, 1'b0, 1'b0, PASS,  1'b1, 1'b0, PASS, 4'd0, 4'd0));
      tbl.push_back(mk("lw5",      1'b1, 1'b0, 1'b0, LW5,   1'b1, 1'b0, LW5,  4'd0, 4'd0));
      tbl.push_back(mk("lu_stall", 1'b1, 1'b0, 1'b0, ADD5,  1'b1, 1'b1, BUB,  4'd1, 4'd0));
      tbl.push_back(mk("lu_load",  1'b1, 1'b0, 1'b0, ADD5,  1'b1, 1'b0, ADD5, 4'd1, 4'd0));
      tbl.push_back(mk("lw0",      1'b1, 1'b0, 1'b0, LW0,   1'b1, 1'b0, LW0,  4'd1, 4'd0));
      tbl.push_back(mk("x0_use",   1'b1, 1'b0, 1'b0, ADD0,  1'b1, 1'b0, ADD0, 4'd1, 4'd0));
      tbl.push_back(mk("lw5_b",    1'b1, 1'b0, 1'b0, LW5,   1'b1, 1'b0, LW5,  4'd1, 4'd0));
      tbl.push_back(mk("rs2_nouse",1'b1, 1'b0, 1'b0, ADDI,  1'b1, 1'b0, ADDI, 4'd1, 4'd0));
      tbl.push_back(mk("lw5_c",    1'b1, 1'b0, 1'b0, LW5,   1'b1, 1'b0, LW5,  4'd1, 4'd0));
      tbl.push_back(mk("rs2_stall",1'b1, 1'b0, 1'b0, SW5,   1'b1, 1'b1, BUB,  4'd2, 4'd0));
      tbl.push_back(mk("rs2_load", 1'b1, 1'b0, 1'b0, SW5,   1'b1, 1'b0, SW5,  4'd2, 4'd0));
      tbl.push_back(mk("lw5_d",    1'b1, 1'b0, 1'b0, LW5,   1'b1, 1'b0, LW5,  4'd2, 4'd0));
      tbl.push_back(mk("flush_haz",1'b1, 1'b0, 1'b1, ADD5,  1'b1, 1'b0, BUB,  4'd2, 4'd1));
      tbl.push_back(mk("lw_inval", 1'b1, 1'b0, 1'b0, LW5I,  1'b1, 1'b0, LW5I, 4'd2, 4'd1));
      tbl.push_back(mk("ex_inval", 1'b1, 1'b0, 1'b0, ADD5,  1'b1, 1'b0, ADD5, 4'd2, 4'd1));
      tbl.push_back(mk("lw5_e",    1'b1, 1'b0, 1'b0, LW5,   1'b1, 1'b0, LW5,  4'd2, 4'd1));
      tbl.push_back(mk("id_inval", 1'b1, 1'b0, 1'b0, ADD5I, 1'b1, 1'b0, ADD5I,4'd2, 4'd1));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].name, tbl[i].rst, tbl[i].frz, tbl[i].fl, tbl[i].id, tbl[i].chk_st,
              tbl[i].exp_st, tbl[i].exp_ex, tbl[i].exp_sc, tbl[i].exp_fc);
      end

      // Freeze during a pending hazard: everything holds, stall resolves afterwards.
      step("frz_ld", 1'b1, 1'b0, 1'b0, LW5, 1'b1, 1'b0, LW5, 4'd2, 4'd1);
      for (int k = 0; k < 3; k++) begin
         step("frz_hold", 1'b1, 1'b1, 1'b0, ADD5, 1'b1, 1'b1, LW5, 4'd2, 4'd1);
      end
      step("frz_flush", 1'b1, 1'b1, 1'b1, ADD5, 1'b1, 1'b0, LW5,  4'd2, 4'd1);
      step("frz_rel",   1'b1, 1'b0, 1'b0, ADD5, 1'b1, 1'b1, BUB,  4'd3, 4'd1);
      step("frz_add",   1'b1, 1'b0, 1'b0, ADD5, 1'b1, 1'b0, ADD5, 4'd3, 4'd1);

      // Reset wins over freeze.
      step("rst_ld",    1'b1, 1'b0, 1'b0, LW5,  1'b1, 1'b0, LW5,  4'd3, 4'd1);
      step("rst_frz",   1'b1, 1'b1, 1'b0, ADD5, 1'b1, 1'b1, LW5,  4'd3, 4'd1);
      step("rst_mid",   1'b0, 1'b1, 1'b0, ADD5, 1'b1, 1'b1, BUB,  4'd0, 4'd0);
      step("rst_after", 1'b1, 1'b1, 1'b0, ADD5, 1'b1, 1'b0, BUB,  4'd0, 4'd0);

      // 20 load-use events against a 4-bit counter.
      s = '0;
      for (int i = 0; i < 20; i++) begin
         step("sat_lw", 1'b1, 1'b0, 1'b0, LW5, 1'b1, 1'b0, LW5, s, 4'd0);
         s = (i + 1 >= 15) ? 4'd15 : 4'(i + 1);
         step("sat_use", 1'b1, 1'b0, 1'b0, ADD5, 1'b1, 1'b1, BUB, s, 4'd0);
      end

      f = '0;
      for (int i = 0; i < 20; i++) begin
         f = (i + 1 >= 15) ? 4'd15 : 4'(i + 1);
         step("sat_fl", 1'b1, 1'b0, 1'b1, ADD5, 1'b1, 1'b0, BUB, 4'd15, f);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
